// File: rtl/speaker_sample_buffer.sv
// ---------------------------------------------------------------------------
// speaker_sample_buffer
//
// Elastic sample buffer between the E100 speaker I/O port and the audio DAC
// path. Everything runs on `clock`. The CPU writes samples over a four-phase
// command/response handshake and they are queued in a FIFO. One sample is
// released per rising edge of the asynchronous 8.1 kHz `clock_8_1k`, which is
// synchronized and edge-detected here.
//
// Optional feature macro: SPEAKER_UNDERFLOW_COUNT_EN
//   When defined, adds a saturating 16-bit `underflow_count` output. A write of
//   16'h8000 into an empty FIFO clears it, and that sample is still queued.
//
// Ports:
//   clock            in   main E100 clock, rising edge
//   reset            in   asynchronous active-high reset
//   clock_8_1k       in   8.1 kHz sample clock (asynchronous)
//   speaker_command  in   CPU write request (level)
//   speaker_data     in   sample to queue, stable while command is high
//   speaker_response out  write acknowledge (level)
//   sample_out       out  current DAC sample (registered)
//   sample_strobe    out  one-cycle pulse when sample_out updates
//   underflow        out  one-cycle pulse when a tick finds the FIFO empty
//   level            out  FIFO occupancy, 0..2^DEPTH_LOG2
//   underflow_count  out  (macro only) saturating underflow counter
// ---------------------------------------------------------------------------
module speaker_sample_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clock_8_1k,
  input  logic                  speaker_command,
  input  logic [WIDTH-1:0]      speaker_data,
  output logic                  speaker_response,
  output logic [WIDTH-1:0]      sample_out,
  output logic                  sample_strobe,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   level
`ifdef SPEAKER_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]           underflow_count
`endif
);

  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   ZERO_LEVEL = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   ONE_LEVEL  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR    = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } wr_state_t;

  wr_state_t             state_r;
  logic                  s1_r, s2_r, s3_r;
  logic [DEPTH_LOG2-1:0] wptr_r, rptr_r;
  logic [WIDTH-1:0]      mem_r [0:(1<<DEPTH_LOG2)-1];
  logic                  tick_s, push_s, pop_s, empty_tick_s;

  // Decode tick, push and pop from registered state at the start of the cycle.
  always_comb begin
    tick_s       = s2_r & ~s3_r;
    push_s       = (state_r == IDLE) && speaker_command && (level < FULL_LEVEL);
    pop_s        = tick_s && (level != ZERO_LEVEL);
    empty_tick_s = tick_s && (level == ZERO_LEVEL);
  end

  // Sample-clock synchronizer; resets high so a level already high at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= clock_8_1k;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Write handshake FSM with registered acknowledge: one push per command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      speaker_response <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (push_s) begin
            speaker_response <= 1'b1;
            state_r          <= ACKED;
          end else begin
            speaker_response <= 1'b0;
          end
        end
        ACKED: begin
          if (!speaker_command) begin
            speaker_response <= 1'b0;
            state_r          <= IDLE;
          end else begin
            speaker_response <= 1'b1;
          end
        end
        default: begin
          speaker_response <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below `level`, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wptr_r] <= speaker_data;
    end
  end

  // Pointers, occupancy counter and DAC-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_r        <= '0;
      rptr_r        <= '0;
      level         <= ZERO_LEVEL;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rptr_r     <= rptr_r + ONE_PTR;
        sample_out <= mem_r[rptr_r];
      end
      sample_strobe <= pop_s;
      underflow     <= empty_tick_s;
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push_s, pop_s})
        2'b10:   level <= level + ONE_LEVEL;
        2'b01:   level <= level - ONE_LEVEL;
        default: level <= level;
      endcase
    end
  end

`ifdef SPEAKER_UNDERFLOW_COUNT_EN
  // Saturating underflow counter; a 16'h8000 write into an empty FIFO clears
  // it and takes priority over a coincident increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow_count <= 16'h0000;
    end else if (push_s && (speaker_data == WIDTH'(16'h8000)) && (level == ZERO_LEVEL)) begin
      underflow_count <= 16'h0000;
    end else if (empty_tick_s && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'h0001;
    end else begin
      underflow_count <= underflow_count;
    end
  end
`endif

endmodule
